// File: rtl/boom_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// boom_run_ctrl_if
//   Command and core-control bundle of the BOOM tile run-state sequencer.
//   The slave modport is the sequencer's side; the master modport is the
//   tile control registers and core side (or a bench).
//
//   Handshake: a command transfers at a posedge of clk_i where both
//   cmd_valid_i and cmd_ready_o are 1. cmd_ready_o depends only on the
//   sequencer state, never on cmd_valid_i. A master holding cmd_valid_i
//   high keeps cmd_op_i stable until the transfer happens.
//
//   cmd_valid_i    command valid
//   cmd_op_i       00 nop, 01 start, 10 stop, 11 restart
//   cmd_ready_o    sequencer can take a command (OFF or RUN)
//   core_idle_i    core drained (synchronous to clk_i)
//   core_quiesce_o ask the core to stop fetching and drain
//   core_en_o      core enable to the clock-gate/reset controller
//   busy_o         sequencer is between stable states
//   state_o        current state encoding (debug/observability)
//   timeout_o      sticky flag: a drain ended by timeout
//   timeout_clr_i  clears timeout_o
// ---------------------------------------------------------------------------
interface boom_run_ctrl_if;
  logic       cmd_valid_i;
  logic [1:0] cmd_op_i;
  logic       cmd_ready_o;
  logic       core_idle_i;
  logic       core_quiesce_o;
  logic       core_en_o;
  logic       busy_o;
  logic [2:0] state_o;
  logic       timeout_o;
  logic       timeout_clr_i;

  modport master (
    output cmd_valid_i, cmd_op_i, core_idle_i, timeout_clr_i,
    input  cmd_ready_o, core_quiesce_o, core_en_o, busy_o, state_o, timeout_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, core_idle_i, timeout_clr_i,
    output cmd_ready_o, core_quiesce_o, core_en_o, busy_o, state_o, timeout_o
  );
endinterface

// File: rtl/boom_run_ctrl.sv
// ---------------------------------------------------------------------------
// boom_run_ctrl
//   Run-state sequencer for one BOOM core tile. Takes start/stop/restart
//   commands, drives core_en into the core clock-gate/reset controller, and
//   drains the core (quiesce, then wait for idle or timeout) before gating.
//   After enabling, it waits START_CYCLES for the downstream enable sync and
//   reset release before reporting RUN.
//
//   Ports:
//     clk_i    tile clock (ungated)
//     reset_i  asynchronous reset, active high
//     ctrl     boom_run_ctrl_if.slave (command handshake, core control,
//              status and debug state)
//
//   States: OFF=0, STARTING=1, RUN=2, DRAIN=3, GATE=4. Any other encoding
//   behaves and decodes as OFF. Every output is decoded from registered
//   state only, so nothing on an input reaches an output combinationally,
//   and asynchronous reset drops core_en_o immediately.
// ---------------------------------------------------------------------------
module boom_run_ctrl #(
  parameter int START_CYCLES  = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int GATE_CYCLES   = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  boom_run_ctrl_if.slave  ctrl
);

  localparam int MAX_SG  = (START_CYCLES > GATE_CYCLES) ? START_CYCLES : GATE_CYCLES;
  localparam int MAX_ALL = (MAX_SG > DRAIN_TIMEOUT) ? MAX_SG : DRAIN_TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL + 1);

  // With DRAIN_TIMEOUT=0 the drain waits forever; the counter is unused then.
  localparam int DRAIN_LOAD_I = (DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1;

  localparam logic [CW-1:0] START_LOAD = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_LOAD_I);
  localparam logic [CW-1:0] GATE_LOAD  = CW'(GATE_CYCLES - 1);

  localparam logic [1:0] OP_START   = 2'b01;
  localparam logic [1:0] OP_STOP    = 2'b10;
  localparam logic [1:0] OP_RESTART = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_STARTING = 3'd1,
    ST_RUN      = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_GATE     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            restart_q, restart_d;
  logic            timeout_q;
  logic            timeout_set;
  logic            ready;
  logic            accept;
  logic            cnt_zero;

  // ---------------------------------------------------------------- outputs
  always_comb begin
    ready               = 1'b0;
    ctrl.busy_o         = 1'b0;
    ctrl.core_en_o      = 1'b0;
    ctrl.core_quiesce_o = 1'b0;
    ctrl.state_o        = ST_OFF;
    case (state_q)
      ST_STARTING: begin
        ctrl.busy_o    = 1'b1;
        ctrl.core_en_o = 1'b1;
        ctrl.state_o   = ST_STARTING;
      end
      ST_RUN: begin
        ready          = 1'b1;
        ctrl.core_en_o = 1'b1;
        ctrl.state_o   = ST_RUN;
      end
      ST_DRAIN: begin
        ctrl.busy_o         = 1'b1;
        ctrl.core_en_o      = 1'b1;
        ctrl.core_quiesce_o = 1'b1;
        ctrl.state_o        = ST_DRAIN;
      end
      ST_GATE: begin
        ctrl.busy_o  = 1'b1;
        ctrl.state_o = ST_GATE;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  assign ctrl.cmd_ready_o = ready;
  assign ctrl.timeout_o   = timeout_q;
  assign accept           = ctrl.cmd_valid_i & ready;
  assign cnt_zero         = (cnt_q == '0);

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    restart_d   = restart_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_STARTING: begin
        if (cnt_zero) state_d = ST_RUN;
        else          cnt_d   = cnt_q - CW'(1);
      end
      ST_RUN: begin
        if (accept && (ctrl.cmd_op_i == OP_STOP || ctrl.cmd_op_i == OP_RESTART)) begin
          state_d   = ST_DRAIN;
          cnt_d     = DRAIN_LOAD;
          restart_d = (ctrl.cmd_op_i == OP_RESTART);
        end
      end
      ST_DRAIN: begin
        // Idle has priority over an expiring timeout in the same cycle.
        if (ctrl.core_idle_i) begin
          state_d = ST_GATE;
          cnt_d   = GATE_LOAD;
        end else if (DRAIN_TIMEOUT != 0 && cnt_zero) begin
          state_d     = ST_GATE;
          cnt_d       = GATE_LOAD;
          timeout_set = 1'b1;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GATE: begin
        if (cnt_zero) begin
          if (restart_q) begin
            state_d   = ST_STARTING;
            cnt_d     = START_LOAD;
            restart_d = 1'b0;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        // OFF and any unreachable encoding: stop/nop are accepted and ignored.
        state_d = ST_OFF;
        if (accept && (ctrl.cmd_op_i == OP_START || ctrl.cmd_op_i == OP_RESTART)) begin
          state_d = ST_STARTING;
          cnt_d   = START_LOAD;
        end
      end
    endcase
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                 timeout_q <= 1'b0;
    else if (timeout_set)        timeout_q <= 1'b1;
    else if (ctrl.timeout_clr_i) timeout_q <= 1'b0;
  end

endmodule

// File: tb/tb_boom_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boom_run_ctrl
//   Directed bench for boom_run_ctrl with START_CYCLES=16, DRAIN_TIMEOUT=8,
//   GATE_CYCLES=8. Inputs are driven and outputs sampled 1 ns after each
//   rising clock edge.
// ---------------------------------------------------------------------------
module tb_boom_run_ctrl;

  localparam int START_CYCLES  = 16;
  localparam int DRAIN_TIMEOUT = 8;
  localparam int GATE_CYCLES   = 8;

  localparam logic [2:0] S_OFF = 3'd0, S_STARTING = 3'd1, S_RUN = 3'd2,
                         S_DRAIN = 3'd3, S_GATE = 3'd4;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boom_run_ctrl_if bus ();

  boom_run_ctrl #(
    .START_CYCLES  (START_CYCLES),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
    .GATE_CYCLES   (GATE_CYCLES)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .ctrl    (bus)
  );

  // ------------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 2'b00;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cycles, input string tag);
    int n;
    n = 0;
    while (bus.state_o !== s && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, bus.state_o, s);
  endtask

  task automatic go_run(input string tag);
    send_cmd(2'b01);
    wait_state(S_RUN, START_CYCLES + 4, tag);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_state"},   bus.state_o,        S_OFF);
    check({pfx, "_ready"},   bus.cmd_ready_o,    1'b1);
    check({pfx, "_en"},      bus.core_en_o,      1'b0);
    check({pfx, "_busy"},    bus.busy_o,         1'b0);
    check({pfx, "_quiesce"}, bus.core_quiesce_o, 1'b0);
    check({pfx, "_timeout"}, bus.timeout_o,      1'b0);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_op_i      = 2'b00;
    bus.core_idle_i   = 1'b0;
    bus.timeout_clr_i = 1'b0;

    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("post_rst");

    // T1: start -> core_en next cycle, RUN START_CYCLES cycles later.
    send_cmd(2'b01);
    check("t1_en",    bus.core_en_o,   1'b1);
    check("t1_busy",  bus.busy_o,      1'b1);
    check("t1_ready", bus.cmd_ready_o, 1'b0);
    check("t1_state", bus.state_o,     S_STARTING);
    for (int i = 0; i < START_CYCLES - 1; i++) tick();
    check("t1_still_starting", bus.state_o, S_STARTING);
    tick();
    check("t1_run",      bus.state_o,     S_RUN);
    check("t1_run_rdy",  bus.cmd_ready_o, 1'b1);
    check("t1_run_busy", bus.busy_o,      1'b0);
    check("t1_run_en",   bus.core_en_o,   1'b1);

    // T2: stop, idle arrives in the 6th drain cycle -> 6 quiesce cycles, 8 gate cycles.
    send_cmd(2'b10);
    for (int i = 0; i < 6; i++) begin
      check("t2_drain_state", bus.state_o,        S_DRAIN);
      check("t2_quiesce",     bus.core_quiesce_o, 1'b1);
      if (i == 5) bus.core_idle_i = 1'b1;
      tick();
    end
    for (int i = 0; i < GATE_CYCLES; i++) begin
      check("t2_gate_state", bus.state_o,        S_GATE);
      check("t2_gate_en",    bus.core_en_o,      1'b0);
      check("t2_gate_qui",   bus.core_quiesce_o, 1'b0);
      tick();
    end
    bus.core_idle_i = 1'b0;
    check("t2_off",     bus.state_o,   S_OFF);
    check("t2_timeout", bus.timeout_o, 1'b0);

    // T3: drain times out after DRAIN_TIMEOUT cycles; clear held across the
    // timeout edge loses to the set, then clears on the following edge.
    go_run("t3_run");
    send_cmd(2'b10);
    bus.timeout_clr_i = 1'b1;
    for (int i = 0; i < DRAIN_TIMEOUT; i++) begin
      check("t3_drain_state", bus.state_o,   S_DRAIN);
      check("t3_no_to_yet",   bus.timeout_o, 1'b0);
      tick();
    end
    check("t3_gate",       bus.state_o,   S_GATE);
    check("t3_to_setwins", bus.timeout_o, 1'b1);
    tick();
    bus.timeout_clr_i = 1'b0;
    check("t3_to_cleared", bus.timeout_o, 1'b0);
    wait_state(S_OFF, GATE_CYCLES + 2, "t3_off");

    // T4: restart with idle high walks DRAIN, GATE, STARTING, RUN; ready stays low.
    go_run("t4_run");
    bus.core_idle_i = 1'b1;
    exp_q.push_back(S_DRAIN);
    for (int i = 0; i < GATE_CYCLES; i++)  exp_q.push_back(S_GATE);
    for (int i = 0; i < START_CYCLES; i++) exp_q.push_back(S_STARTING);
    exp_q.push_back(S_RUN);
    send_cmd(2'b11);
    while (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      check("t4_seq_state", bus.state_o, e);
      check("t4_seq_ready", bus.cmd_ready_o, (e == S_RUN) ? 1'b1 : 1'b0);
      if (e != S_RUN) tick();
    end
    bus.core_idle_i = 1'b0;

    // T5: stop held valid from RUN entry: not taken until ready. Go OFF first.
    send_cmd(2'b10);
    wait_state(S_OFF, DRAIN_TIMEOUT + GATE_CYCLES + 4, "t5_off");
    bus.timeout_clr_i = 1'b1;
    tick();
    bus.timeout_clr_i = 1'b0;
    send_cmd(2'b01);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = 2'b10;
    for (int i = 0; i < START_CYCLES; i++) begin
      check("t5_hold_starting", bus.state_o, S_STARTING);
      tick();
    end
    check("t5_run_first", bus.state_o, S_RUN);
    tick();
    bus.cmd_valid_i = 1'b0;
    check("t5_stop_taken", bus.state_o, S_DRAIN);
    // Idle arrives exactly as the drain counter reaches 0: no timeout.
    for (int i = 0; i < DRAIN_TIMEOUT; i++) begin
      if (i == DRAIN_TIMEOUT - 1) bus.core_idle_i = 1'b1;
      tick();
    end
    bus.core_idle_i = 1'b0;
    check("t5_tie_gate",  bus.state_o,   S_GATE);
    check("t5_tie_no_to", bus.timeout_o, 1'b0);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = 2'b01;
    for (int i = 0; i < GATE_CYCLES; i++) begin
      check("t5_hold_gate", bus.state_o, S_GATE);
      tick();
    end
    check("t5_off_once", bus.state_o, S_OFF);
    tick();
    bus.cmd_valid_i = 1'b0;
    check("t5_start_taken", bus.state_o, S_STARTING);
    wait_state(S_RUN, START_CYCLES + 2, "t5_run");

    // T6: get timeout set, then assert reset mid-DRAIN between clock edges.
    send_cmd(2'b10);
    wait_state(S_OFF, DRAIN_TIMEOUT + GATE_CYCLES + 4, "t6_off");
    check("t6_to_set", bus.timeout_o, 1'b1);
    go_run("t6_run");
    send_cmd(2'b10);
    tick();
    check("t6_in_drain", bus.state_o, S_DRAIN);
    check("t6_en_pre",   bus.core_en_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    #2;
    rst = 1'b0;
    tick();
    send_cmd(2'b01);
    check("t6_restart_en", bus.core_en_o, 1'b1);
    for (int i = 0; i < START_CYCLES; i++) tick();
    check("t6_run_again", bus.state_o, S_RUN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
